// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub shared types and helpers.
// Stage-register bundle and geometry function.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic valid;
    logic carry;
    logic zero;
    logic sign_a;
    logic sign_b;
  } stage_t;

  function automatic int stages_of(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// pipe_addsub operand/result handshake bundle.
// master drives operands, slave is the unit.
interface pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_sub,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_carry,
    input  out_overflow,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_sub,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_carry,
    output out_overflow,
    output out_zero
  );

endinterface

// File: rtl/addsub_slice.sv
// One CHUNK-bit add stage with its register.
// Consumed operand slices are dropped as they pass.
module addsub_slice
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  stage_t           ctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  output stage_t           ctl_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o
);

  localparam int LO = IDX * CHUNK;
  localparam logic [WIDTH-1:0] KEEP =
    {WIDTH{1'b1}} << (LO + CHUNK);

  logic [CHUNK:0]   add;
  logic [WIDTH-1:0] s_n;

  // Slice adder with the incoming carry.
  always_comb begin
    add = {1'b0, a_i[LO +: CHUNK]}
        + {1'b0, b_i[LO +: CHUNK]}
        + {{CHUNK{1'b0}}, ctl_i.carry};
  end

  // Merge this slice into the riding sum.
  always_comb begin
    s_n = s_i;
    s_n[LO +: CHUNK] = add[CHUNK-1:0];
  end

  // Stage register; holds everything when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_o <= '0;
      a_o   <= '0;
      b_o   <= '0;
      s_o   <= '0;
    end else if (adv) begin
      ctl_o <= '{
        valid:  ctl_i.valid,
        carry:  add[CHUNK],
        zero:   ctl_i.zero & ~|add[CHUNK-1:0],
        sign_a: ctl_i.sign_a,
        sign_b: ctl_i.sign_b
      };
      a_o <= a_i & KEEP;
      b_o <= b_i & KEEP;
      s_o <= s_n;
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, one CHUNK slice per stage.
// Global advance stalls every stage together.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0 || STAGES < 1) begin : g_bad
    $error("pipe_addsub: WIDTH must be a multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  stage_t           ctl [0:STAGES];
  logic [WIDTH-1:0] a_p [0:STAGES];
  logic [WIDTH-1:0] b_p [0:STAGES];
  logic [WIDTH-1:0] s_p [0:STAGES];

  assign adv = !ctl[STAGES].valid | bus.out_ready;
  assign bus.in_ready = adv;

  assign b_eff = (bus.in_sub == OP_SUB) ? ~bus.in_b
                                        : bus.in_b;

  assign ctl[0] = '{
    valid:  bus.in_valid,
    carry:  bus.in_sub,
    zero:   1'b1,
    sign_a: bus.in_a[WIDTH-1],
    sign_b: b_eff[WIDTH-1]
  };
  assign a_p[0] = bus.in_a;
  assign b_p[0] = b_eff;
  assign s_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .ctl_i (ctl[k]),
      .a_i   (a_p[k]),
      .b_i   (b_p[k]),
      .s_i   (s_p[k]),
      .ctl_o (ctl[k+1]),
      .a_o   (a_p[k+1]),
      .b_o   (b_p[k+1]),
      .s_o   (s_p[k+1])
    );
  end

  assign bus.out_valid = ctl[STAGES].valid;
  assign bus.out_sum   = s_p[STAGES];
  assign bus.out_carry = ctl[STAGES].carry;
  assign bus.out_zero  = ctl[STAGES].zero;
  assign bus.out_overflow =
    (ctl[STAGES].sign_a == ctl[STAGES].sign_b) &
    (s_p[STAGES][WIDTH-1] != ctl[STAGES].sign_a);

endmodule

// File: tb/tb_pipe_addsub.sv
// pipe_addsub bench: directed corners, reset flush,
// random backpressured stream and width sweeps.
module tb_pipe_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(16)) bus16 ();
  pipe_addsub_if #(.WIDTH(32)) bus32 ();
  pipe_addsub_if #(.WIDTH(8))  bus8  ();

  pipe_addsub #(.WIDTH(16), .CHUNK(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );
  pipe_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32)
  );
  pipe_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  function automatic logic [18:0] model16(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        sub
  );
    int unsigned ua, ub, ur;
    int sa, sb, r;
    logic c, ov;
    logic [15:0] s;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      ur = (ua + 65536 - ub) % 65536;
      c = (ua >= ub);
      r = sa - sb;
    end else begin
      ur = (ua + ub) % 65536;
      c = (ua + ub) > 65535;
      r = sa + sb;
    end
    s = 16'(ur);
    ov = (r > 32767) || (r < -32768);
    return {c, ov, (s == 16'h0), s};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom % 8)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [18:0] obs16();
    return {bus16.out_carry, bus16.out_overflow,
            bus16.out_zero, bus16.out_sum};
  endfunction

  task automatic run16(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        sub,
    input logic [18:0] exp,
    input int          lat,
    input string       tag
  );
    int cyc;
    @(negedge clk);
    bus16.out_ready = 1'b1;
    bus16.in_a = a;
    bus16.in_b = b;
    bus16.in_sub = sub;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    cyc = 1;
    while (!bus16.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk(tag, 64'(obs16()), 64'(exp));
  endtask

  task automatic run32(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [34:0] exp,
    input string       tag
  );
    int cyc;
    @(negedge clk);
    bus32.in_a = a;
    bus32.in_b = b;
    bus32.in_sub = 1'b0;
    bus32.in_valid = 1'b1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    cyc = 1;
    while (!bus32.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd4);
    chk(tag, 64'({bus32.out_carry, bus32.out_overflow,
                  bus32.out_zero, bus32.out_sum}),
        64'(exp));
  endtask

  task automatic run8(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [10:0] exp,
    input string       tag
  );
    int cyc;
    @(negedge clk);
    bus8.in_a = a;
    bus8.in_b = b;
    bus8.in_sub = 1'b0;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    cyc = 1;
    while (!bus8.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd1);
    chk(tag, 64'({bus8.out_carry, bus8.out_overflow,
                  bus8.out_zero, bus8.out_sum}),
        64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] q[$];
    logic [18:0] held;
    logic [18:0] obs;
    logic        hold;
    int sent, got, cyc;

    bus16.in_valid = 1'b0;
    bus16.in_a = '0;
    bus16.in_b = '0;
    bus16.in_sub = 1'b0;
    bus16.out_ready = 1'b1;
    bus32.in_valid = 1'b0;
    bus32.in_a = '0;
    bus32.in_b = '0;
    bus32.in_sub = 1'b0;
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.in_a = '0;
    bus8.in_b = '0;
    bus8.in_sub = 1'b0;
    bus8.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus16.out_valid), 64'd0);
    chk("rst_out", 64'(obs16()), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(bus16.in_ready), 64'd1);

    run16(16'h7FFF, 16'h0001, 1'b0,
          {1'b0, 1'b1, 1'b0, 16'h8000}, 2, "add_ovf");
    run16(16'hFFFF, 16'h0001, 1'b0,
          {1'b1, 1'b0, 1'b1, 16'h0000}, 2, "add_wrap");
    run16(16'h0000, 16'h0001, 1'b1,
          {1'b0, 1'b0, 1'b0, 16'hFFFF}, 2, "sub_borrow");
    run16(16'h8000, 16'h0001, 1'b1,
          {1'b1, 1'b1, 1'b0, 16'h7FFF}, 2, "sub_ovf");

    run32(32'h7FFF_FFFF, 32'h1,
          {1'b0, 1'b1, 1'b0, 32'h8000_0000}, "w32_ovf");
    run32(32'hFFFF_FFFF, 32'h1,
          {1'b1, 1'b0, 1'b1, 32'h0}, "w32_wrap");
    run8(8'h7F, 8'h01, {1'b0, 1'b1, 1'b0, 8'h80},
         "w8_ovf");
    run8(8'hFF, 8'h01, {1'b1, 1'b0, 1'b1, 8'h00},
         "w8_wrap");

    // Two beats in flight, then a one-cycle reset.
    @(negedge clk);
    bus16.out_ready = 1'b1;
    bus16.in_a = 16'h1234;
    bus16.in_b = 16'h1111;
    bus16.in_sub = 1'b0;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_a = 16'h2222;
    bus16.in_b = 16'h0001;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus16.out_valid), 64'd0);
    chk("mid_rst_out", 64'(obs16()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus16.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ghost", 64'(bus16.out_valid), 64'd0);
    end
    run16(16'h0003, 16'h0004, 1'b0,
          {1'b0, 1'b0, 1'b0, 16'h0007}, 2, "post_rst");

    // Random stream with random backpressure.
    sent = 0;
    got = 0;
    cyc = 0;
    hold = 1'b0;
    held = '0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus16.out_ready = ($urandom % 3) != 0;
      if (sent < 100 && ($urandom % 4) != 0) begin
        bus16.in_valid = 1'b1;
        bus16.in_a = rnd16();
        bus16.in_b = rnd16();
        bus16.in_sub = 1'($urandom % 2);
      end else begin
        bus16.in_valid = 1'b0;
      end
      #1;
      obs = obs16();
      if (hold) begin
        chk("stall_valid", 64'(bus16.out_valid), 64'd1);
        chk("stall_data", 64'(obs), 64'(held));
      end
      chk("in_ready", 64'(bus16.in_ready),
          64'(!bus16.out_valid | bus16.out_ready));
      if (bus16.out_valid && bus16.out_ready) begin
        if (q.size() == 0)
          chk("extra_beat", 64'd1, 64'(q.size()));
        else
          chk("beat", 64'(obs), 64'(q.pop_front()));
        got++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        q.push_back(model16(bus16.in_a, bus16.in_b,
                            bus16.in_sub));
        sent++;
      end
      hold = bus16.out_valid && !bus16.out_ready;
      held = obs;
    end
    bus16.in_valid = 1'b0;
    chk("drained", 64'(got), 64'd100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
